// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data stage.
// Data wins by default; a fetch port starved for STARVE_MAX cycles is forced through.
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              stall_if,
    output logic [15:0]       conflict_cnt
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic [SW-1:0] starve;
    logic          tag_i;
    logic          tag_d;
    logic          both;
    logic          force_i;

    assign both    = i_req & d_req;
    assign force_i = both & (starve == STARVE_TOP);

    assign d_gnt    = ~rst & d_req & ~force_i;
    assign i_gnt    = ~rst & i_req & (~d_req | force_i);
    assign stall_if = i_req & ~i_gnt;
    assign mem_wren = d_gnt & d_we;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            d_gnt: begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            i_gnt: mem_addr = i_addr;
            default: ;
        endcase
    end

    // Gating with rst hides a tag set by a read granted just before reset.
    assign i_rvalid = tag_i & ~rst;
    assign d_rvalid = tag_d & ~rst;
    assign i_rdata  = i_rvalid ? mem_q : '0;
    assign d_rdata  = d_rvalid ? mem_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve       <= '0;
            tag_i        <= 1'b0;
            tag_d        <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (i_gnt || !i_req)
                starve <= '0;
            else if (starve != STARVE_TOP)
                starve <= starve + SW'(1);
            tag_i <= i_gnt;
            tag_d <= d_gnt & ~d_we;
            if (both && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule
